// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared types for the RPN stack sequencer: FSM/undo enums, opcode and flag widths.
package rpn_ctrl_pkg;
    localparam int FLAGS_W = 4;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;
    typedef enum logic [0:0] {UNDO_PUSH = 1'b0, UNDO_EXEC = 1'b1} undo_kind_t;
    typedef logic [1:0] opcode_t;
endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Bundle between the stack sequencer (master) and the external combinational ALU (slave).
interface rpn_stack_ctrl_if #(parameter int WIDTH = 16);
    import rpn_ctrl_pkg::*;

    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    opcode_t            alu_opcode;
    logic [WIDTH-1:0]   alu_result;
    logic [FLAGS_W-1:0] alu_flags;

    modport master (output alu_a, alu_b, alu_opcode, input alu_result, alu_flags);
    modport slave  (input alu_a, alu_b, alu_opcode, output alu_result, alu_flags);
endinterface

// File: rtl/rpn_stack_ctrl_rf.sv
// DEPTH x WIDTH operand stack storage: one write port, a paired restore port
// (writes rs_addr and rs_addr+1 together) and two combinational read ports.
module rpn_stack_rf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rs_en,
    input  logic [2:0]       rs_addr,
    input  logic [WIDTH-1:0] rs_lo,
    input  logic [WIDTH-1:0] rs_hi,
    input  logic [2:0]       rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    input  logic [2:0]       rd1_addr,
    output logic [WIDTH-1:0] rd1_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]       rs_addr_hi;

    assign rs_addr_hi = rs_addr + 3'd1;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset)
                mem[i] <= '0;
            else if (rs_en && rs_addr == 3'(i))
                mem[i] <= rs_lo;
            else if (rs_en && rs_addr_hi == 3'(i))
                mem[i] <= rs_hi;
            else if (wr_en && wr_addr == 3'(i))
                mem[i] <= wr_data;
        end
    end

    // Out-of-range addresses (sp below 2 wraps) read as zero.
    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd0_addr == 3'(i)) rd0_data = mem[i];
            if (rd1_addr == 3'(i)) rd1_data = mem[i];
        end
    end
endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN operand-stack sequencer: push/exec/undo commands around an external
// combinational ALU, with a single-level undo snapshot.
module rpn_stack_ctrl
    import rpn_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enter_pulse,
    input  logic                 exec_pulse,
    input  logic                 undo_pulse,
    input  logic [WIDTH-1:0]     data_in,
    rpn_stack_ctrl_if.master     alu,
    output logic [WIDTH-1:0]     to_display,
    output logic [FLAGS_W-1:0]   flags,
    output logic [2:0]           depth,
    output logic                 busy,
    output logic                 err
);
    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_EXEC  = ST_EXEC;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [0:0]         state;
    logic [2:0]         sp;
    logic [WIDTH-1:0]   alu_a_q, alu_b_q;
    opcode_t            alu_op_q;
    logic               undo_valid;
    undo_kind_t         undo_kind;
    logic [WIDTH-1:0]   saved_a, saved_b;
    logic [FLAGS_W-1:0] saved_flags;

    logic [WIDTH-1:0]   top_data, below_data;
    logic               idle, do_undo, do_exec, do_push, reject;
    logic               wr_en, rs_en;
    logic [2:0]         wr_addr;
    logic [WIDTH-1:0]   wr_data;

    assign idle = (state == S_IDLE);

    // Undo beats exec beats enter; only the winner is judged for acceptance.
    assign do_undo = idle && undo_pulse && undo_valid;
    assign do_exec = idle && !undo_pulse && exec_pulse && (sp >= 3'd2);
    assign do_push = idle && !undo_pulse && !exec_pulse && enter_pulse && (sp < DEPTH_C);
    assign reject  = idle && ((undo_pulse && !undo_valid) ||
                              (!undo_pulse && exec_pulse && sp < 3'd2) ||
                              (!undo_pulse && !exec_pulse && enter_pulse && sp >= DEPTH_C));

    // The EXEC cycle owns the write port to drop the result into stack[sp-2].
    assign wr_en   = do_push || (state == S_EXEC);
    assign wr_addr = (state == S_EXEC) ? sp - 3'd2 : sp;
    assign wr_data = (state == S_EXEC) ? alu.alu_result : data_in;
    assign rs_en   = do_undo && (undo_kind == UNDO_EXEC);

    rpn_stack_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rs_en    (rs_en),
        .rs_addr  (sp - 3'd1),
        .rs_lo    (saved_a),
        .rs_hi    (saved_b),
        .rd0_addr (sp - 3'd1),
        .rd0_data (top_data),
        .rd1_addr (sp - 3'd2),
        .rd1_data (below_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sp          <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            flags       <= '0;
            err         <= 1'b0;
            undo_valid  <= 1'b0;
            undo_kind   <= UNDO_PUSH;
            saved_a     <= '0;
            saved_b     <= '0;
            saved_flags <= '0;
        end else if (state == S_EXEC) begin
            // Operands are untouched during EXEC, so the read ports still hold the pre-exec pair.
            saved_a     <= below_data;
            saved_b     <= top_data;
            saved_flags <= flags;
            flags       <= alu.alu_flags;
            sp          <= sp - 3'd1;
            undo_kind   <= UNDO_EXEC;
            undo_valid  <= 1'b1;
            state       <= S_IDLE;
        end else begin
            if (reject)
                err <= 1'b1;
            if (do_undo) begin
                err        <= 1'b0;
                undo_valid <= 1'b0;
                if (undo_kind == UNDO_PUSH) begin
                    sp <= sp - 3'd1;
                end else begin
                    sp    <= sp + 3'd1;
                    flags <= saved_flags;
                end
            end
            if (do_exec) begin
                err      <= 1'b0;
                alu_a_q  <= below_data;
                alu_b_q  <= top_data;
                alu_op_q <= data_in[1:0];
                state    <= S_EXEC;
            end
            if (do_push) begin
                err        <= 1'b0;
                sp         <= sp + 3'd1;
                undo_kind  <= UNDO_PUSH;
                undo_valid <= 1'b1;
            end
        end
    end

    assign alu.alu_a      = alu_a_q;
    assign alu.alu_b      = alu_b_q;
    assign alu.alu_opcode = alu_op_q;

    assign to_display = (sp == 3'd0) ? '0 : top_data;
    assign depth      = sp;
    assign busy       = (state == S_EXEC);
endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Sequencer for the calculator's shared ALU using a small operand stack in reverse-Polish style. Debounced Enter pulses push `data_in`. Exec pulses pop the top two entries, run them through the external combinational ALU and push the result. Undo pulses revert the last accepted command (one level). The block sits between the debouncers and the ALU and result-display mux in the calculator top level.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width.
- `DEPTH`, 4, stack entries; legal range 2..7.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enter_pulse`  in  1  one-cycle debounced Enter; push request.
- `exec_pulse`  in  1  one-cycle debounced Exec; operate request.
- `undo_pulse`  in  1  one-cycle debounced Undo.
- `data_in`  in  WIDTH  push value; bits [1:0] are the opcode at exec.
- `alu_a`  out  WIDTH  registered operand A (second-from-top).
- `alu_b`  out  WIDTH  registered operand B (top).
- `alu_opcode`  out  2  registered opcode.
- `alu_result`  in  WIDTH  combinational ALU result.
- `alu_flags`  in  4  combinational ALU flags.
- `to_display`  out  WIDTH  top of stack; 0 when the stack is empty.
- `flags`  out  4  flags of the last completed exec.
- `depth`  out  3  current entry count, 0..DEPTH.
- `busy`  out  1  high while in EXEC.
- `err`  out  1  sticky error; cleared by the next accepted command.

## Operation
- States:
  - IDLE: accepts commands.
  - EXEC: ALU evaluation cycle; always returns to IDLE.
- Command priority when pulses coincide in IDLE: undo > exec > enter. Lower-priority pulses in that cycle are dropped.
- All pulses received in EXEC are dropped silently, with no `err`.
- Push (enter, `depth` < DEPTH):
  - `stack[sp]` <= `data_in`; `sp++`.
  - Snapshot: kind=PUSH, undo_valid=1.
- Exec (`depth` >= 2):
  - Latch `alu_a`=`stack[sp-2]`, `alu_b`=`stack[sp-1]`, `alu_opcode`=`data_in[1:0]`; go to EXEC.
  - In EXEC:
    - Snapshot old `stack[sp-2]`, old `stack[sp-1]` and old `flags`.
    - `stack[sp-2]` <= `alu_result`; `flags` <= `alu_flags`; `sp--`.
    - kind=EXEC, undo_valid=1.
- Undo (undo_valid=1):
  - PUSH: `sp--`.
  - EXEC: restore both saved entries, `sp++` and the saved `flags`.
  - Clears undo_valid, so at most one level of undo.
- Rejected commands set `err`=1 and leave the stack, `sp` and the snapshot unchanged:
  - push when full;
  - exec with `depth` < 2;
  - undo with undo_valid=0.
- `err` clears on the next accepted command.
- Arithmetic is done by the ALU only. The result is truncated to WIDTH. Overflow indication comes solely via `flags`.
- Stack entries above `sp` are don't-care; `to_display` never exposes them.

## Timing
- Reset values: `sp`=0, all stack entries 0, `alu_a`/`alu_b`/`alu_opcode`=0, `flags`=0, `err`=0, `busy`=0, undo_valid=0, state IDLE.
- Reset mid-EXEC aborts the operation; the result is not written.
- Push and undo complete in 1 edge. `to_display` and `depth` reflect the new state the cycle after the pulse.
- Exec:
  - Edge 1 latches the operands; `busy`=1.
  - Edge 2 writes the result, `flags` and `depth`; `busy`=0.
  - Total latency 2 cycles. The next command is accepted in the cycle after edge 2.
- `alu_*` outputs are stable for the entire EXEC cycle. The ALU path must meet one clock period.
- `to_display` and `depth` are combinational from registers, with no extra latency.

## Structure
- Package `rpn_ctrl_pkg` holds:
  - `state_t` {IDLE, EXEC};
  - `undo_kind_t` {PUSH, EXEC};
  - the opcode typedef (2 bits);
  - the `FLAGS_W`=4 constant.
- Optional sub-module `rpn_stack_rf`: DEPTH x WIDTH register file with a synchronous write port, a dual write port for undo-restore, and 2 combinational read ports. The control FSM and snapshot logic stay in `rpn_stack_ctrl`.

## Test plan
- Reset, then push 5, push 3, exec op 0 (add, reference ALU) -> `busy` high for 1 cycle; `to_display`=8, `depth`=1, `flags` from ALU, `err`=0.
- Push 1..4 into DEPTH=4, then push 9 -> `err`=1, `depth`=4, `to_display`=4. Next undo -> `depth`=3, `to_display`=3, `err`=0.
- Push 7, push 2, exec, undo -> `depth`=2, `to_display`=2, entry below=7, `flags` restored to the pre-exec value. Second undo -> `err`=1, no change.
- Exec with `depth`=1 -> `err`=1, `busy` stays 0. Push and undo pulses during EXEC are dropped, and the exec result is still correct.
- `enter_pulse`, `exec_pulse` and `undo_pulse` in the same cycle with undo_valid=1 -> only the undo is performed.
- Assert `reset` during EXEC -> next cycle all outputs are 0 and `depth`=0.
